// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core slice.
// Contents:
//   LDST_*      funct3 encodings of load/store access size
//   lsu_state_t load/store unit handshake state
//   ldst_misaligned() alignment rule for a (size, addr[1:0]) pair
package riscv_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsu_state_t;

    // Halfwords need an even address.
    // Words, including the undefined size codes that are treated as words,
    // need addr[1:0] == 0.
    function automatic logic ldst_misaligned(input logic [2:0] size,
                                             input logic [1:0] addr_lo);
        logic mis;
        case (size)
            LDST_B, LDST_BU: mis = 1'b0;
            LDST_H, LDST_HU: mis = addr_lo[0];
            default:         mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_rd_align.sv
// Load-data aligner: selects the addressed byte or halfword of a memory word
// and sign- or zero-extends it to 32 bits.
// Ports:
//   mem_rd  in  32  raw memory read word
//   size    in  3   access size (LDST_* encoding, undefined codes act as W)
//   addr_lo in  2   byte offset within the word
//   rd      out 32  aligned, extended load data
module lsu_rd_align
    import riscv_pkg::*;
(
    input  logic [31:0] mem_rd,
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    output logic [31:0] rd
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = mem_rd[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? mem_rd[31:16] : mem_rd[15:0];

    always_comb begin
        rd = mem_rd;
        case (size)
            LDST_B:  rd = {{24{byte_sel[7]}}, byte_sel};
            LDST_BU: rd = {24'h0, byte_sel};
            LDST_H:  rd = {{16{half_sel[15]}}, half_sel};
            LDST_HU: rd = {16'h0, half_sel};
            default: rd = mem_rd;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit between the single-cycle core and data memory.
// Turns a raw core request into a word-aligned memory access with byte
// enables and replicated store data, aligns/extends load data, and stalls
// the core until memory answers, a misalignment is rejected or a timeout hits.
// Parameters:
//   TIMEOUT  max WAIT cycles without mem_ready_i before abort (0 = never)
// Ports:
//   clk_i, rst_i (async, active low)
//   core_req_i/we_i/size_i/addr_i/wd_i  core request
//   core_rd_o, core_stall_o             load data and stall back to the core
//   misaligned_o, err_o                 one-cycle abort pulses
//   mem_req_o/we_o/be_o/addr_o/wd_o     memory request
//   mem_rd_i, mem_ready_i               memory response
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        misaligned_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    // A zero-width counter is not legal, so TIMEOUT=0 still gets one bit.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    lsu_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic        misaligned;
    logic        timeout_hit;
    logic        drive_mem;
    logic        rd_valid;
    logic [3:0]  be;
    logic [31:0] wd_rep;
    logic [31:0] rd_aligned;

    assign misaligned  = ldst_misaligned(core_size_i, core_addr_i[1:0]);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        mem_req_o    = 1'b0;
        core_stall_o = 1'b0;
        misaligned_o = 1'b0;
        err_o        = 1'b0;
        drive_mem    = 1'b0;
        rd_valid     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (core_req_i) begin
                    if (misaligned) begin
                        misaligned_o = 1'b1;
                    end else begin
                        mem_req_o    = 1'b1;
                        core_stall_o = 1'b1;
                        drive_mem    = 1'b1;
                        state_next   = WAIT;
                        cnt_next     = '0;
                    end
                end
            end
            WAIT: begin
                // Core inputs are held stable by the stall, so the memory
                // side keeps being driven from them even if core_req_i drops.
                drive_mem = 1'b1;
                if (mem_ready_i) begin
                    rd_valid   = 1'b1;
                    state_next = IDLE;
                end else if (timeout_hit) begin
                    err_o      = 1'b1;
                    state_next = IDLE;
                end else begin
                    core_stall_o = 1'b1;
                    cnt_next     = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        be     = 4'b1111;
        wd_rep = core_wd_i;
        case (core_size_i)
            LDST_B, LDST_BU: begin
                be     = 4'b0001 << core_addr_i[1:0];
                wd_rep = {4{core_wd_i[7:0]}};
            end
            LDST_H, LDST_HU: begin
                be     = core_addr_i[1] ? 4'b1100 : 4'b0011;
                wd_rep = {2{core_wd_i[15:0]}};
            end
            default: begin
                be     = 4'b1111;
                wd_rep = core_wd_i;
            end
        endcase
    end

    lsu_rd_align u_rd_align (
        .mem_rd  (mem_rd_i),
        .size    (core_size_i),
        .addr_lo (core_addr_i[1:0]),
        .rd      (rd_aligned)
    );

    assign mem_we_o   = drive_mem & core_we_i;
    assign mem_be_o   = drive_mem ? be : 4'b0000;
    assign mem_addr_o = drive_mem ? {core_addr_i[31:2], 2'b00} : 32'h0;
    assign mem_wd_o   = drive_mem ? wd_rep : 32'h0;
    assign core_rd_o  = rd_valid ? rd_aligned : 32'h0;

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit directly downstream of the single-cycle core's data-memory port.
- Takes the core's raw request (req, we, size, byte address, write data) and turns it into word-aligned memory accesses with byte enables and store-data replication.
- Sign- or zero-extends and aligns load data back to the core.
- Generates the core's stall signal, holds it until the memory handshake completes, and aborts on misalignment or timeout.

Parameters:
TIMEOUT, 16, maximum WAIT cycles without mem_ready_i before abort (0 = never time out)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
core_req_i  in  1  core requests a data access this cycle
core_we_i  in  1  1 = store, 0 = load
core_size_i  in  3  access size, RISC-V funct3 encoding (LDST_B/H/W/BU/HU)
core_addr_i  in  32  byte address
core_wd_i  in  32  store data, low bytes significant
core_rd_o  out  32  aligned, extended load data
core_stall_o  out  1  freeze core (PC and RF write)
misaligned_o  out  1  one-cycle pulse: misaligned access rejected
err_o  out  1  one-cycle pulse: access aborted by timeout
mem_req_o  out  1  one-cycle request pulse to memory
mem_we_o  out  1  write enable
mem_be_o  out  4  byte enables
mem_addr_o  out  32  word address {core_addr_i[31:2],2'b00}
mem_wd_o  out  32  replicated store data
mem_rd_i  in  32  memory read word, valid when mem_ready_i=1
mem_ready_i  in  1  access complete

Behaviour:
- FSM states: IDLE, WAIT. Wait counter cnt is clog2(TIMEOUT+1) bits.
- Reset (rst_i=0, async): state=IDLE, cnt=0. All outputs are then combinational from the inputs; with core_req_i=0 every output is 0.
- Misaligned access: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - In IDLE: misaligned_o=1, mem_req_o=0, core_stall_o=0, core_rd_o=0.
  - State stays IDLE; no memory side effect.
- IDLE with core_req_i=1 and aligned:
  - mem_req_o=1 and core_stall_o=1 combinationally.
  - Next state WAIT, cnt<=0.
- WAIT:
  - mem_req_o=0. mem_addr/we/be/wd keep being driven from the core inputs, which are stable because the core is stalled.
  - mem_ready_i is sampled only in WAIT, so the minimum memory latency is 1 cycle.
  - mem_ready_i=1: core_stall_o=0 that cycle, core_rd_o is valid that cycle, next state IDLE.
  - mem_ready_i=0, TIMEOUT!=0 and cnt==TIMEOUT-1: core_stall_o=0, err_o=1, core_rd_o=0, next state IDLE.
  - Otherwise: core_stall_o=1, cnt++.
- Latency: an aligned access with ready in cycle 1 stalls the core exactly 1 cycle, so one memory instruction takes 2 cycles.
- Back-to-back accesses: a new request in the cycle after WAIT->IDLE is issued immediately, with no bubble.
- mem_be_o, driven for loads as well as stores:
  - B/BU: 4'b0001<<addr[1:0]
  - H/HU: addr[1] ? 1100 : 0011
  - W: 1111
- mem_wd_o:
  - B: {4{wd[7:0]}}
  - H: {2{wd[15:0]}}
  - W: wd
- core_rd_o:
  - B: byte addr[1:0] of mem_rd_i, sign-extended. BU: same byte, zero-extended.
  - H: half addr[1], sign-extended. HU: same half, zero-extended.
  - W: mem_rd_i.
  - core_rd_o is 0 whenever not (WAIT and mem_ready_i).
- Undefined size codes (3, 6, 7) are handled as W.
- mem_ready_i in IDLE is ignored.
- core_req_i dropping while in WAIT is illegal; the LSU completes the access regardless.
- Reset during WAIT: immediate return to IDLE and stall released; a late mem_ready_i is then ignored.

Decomposition:
- riscv_pkg gains LDST_B=3'd0, LDST_H=3'd1, LDST_W=3'd2, LDST_BU=3'd4, LDST_HU=3'd5 and the lsu_state_t enum {IDLE, WAIT}.
- One combinational sub-module, lsu_rd_align, takes (mem_rd_i, size, addr[1:0]) and produces core_rd_o. It is reused by the later unaligned/MMIO work.

Test Plan:
- Reset, then LB at addr 0x103, mem_rd_i=0x80FF1234, ready in cycle 1 -> mem_be_o=1000; stall high for 1 cycle; core_rd_o=0xFFFFFF80.
- LHU at addr 0x102, mem_rd_i=0xBEEF0000, ready after 3 cycles -> stall high 3 cycles; core_rd_o=0x0000BEEF; mem_addr_o=0x100.
- SB at addr 0x201, core_wd_i=0x000000AB -> mem_we_o=1, mem_be_o=0010, mem_wd_o=0xABABABAB; mem_req_o high exactly one cycle.
- LW at addr 0x006 -> misaligned_o=1, mem_req_o=0, core_stall_o=0 in the same cycle; SH at 0x005 behaves the same way.
- LW with TIMEOUT=4 and mem_ready_i held 0 -> stall high 4 cycles, then err_o pulse, core_rd_o=0, FSM back to IDLE.
- Two consecutive SWs with ready=1 each WAIT cycle -> mem_req_o pulses in cycles 0 and 2; rst_i asserted in WAIT drops stall asynchronously.
